// File: rtl/branch_uop_decoder.sv
// branch_uop_decoder
// Decode-2 branch decoder: recognises b, bc, bclr, bcctr and bctar, and cracks each
// legal branch into 1-3 micro-ops (CTR-decrement, branch, LR-update), one per cycle.
// Optional feature macro: BRANCH_TARGET_CALC_EN (full target / link address adders).
module branch_uop_decoder #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 32,
    parameter int TidSize                 = 64,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 5,
    parameter int opcodeSize              = 12,
    parameter int funcUnitCodeSize        = 3,
    parameter int BranchUnitID            = 6,
    parameter int FXUnitId                = 0,
    parameter int OPC_B                   = 24,
    parameter int OPC_BC                  = 25,
    parameter int OPC_BCLR                = 26,
    parameter int OPC_BCCTR               = 27,
    parameter int OPC_BCTAR               = 28,
    parameter int OPC_CTRDEC              = 29,
    parameter int OPC_LRUPD               = 30
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic                               stall_i,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [instructionCounterWidth-1:0] instructionMajId_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic                               is64Bit_i,
    output logic                               stall_o,
    output logic                               enable_o,
    output logic                               invalid_o,
    output logic [opcodeSize-1:0]              opcode_o,
    output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [instructionCounterWidth-1:0] instMajId_o,
    output logic [PidSize-1:0]                 instPid_o,
    output logic [TidSize-1:0]                 instTid_o,
    output logic                               is64Bit_o,
    output logic [instMinIdWidth-1:0]          instMinId_o,
    output logic [instMinIdWidth-1:0]          numMicroOps_o,
    output logic [4:0]                         bo_o,
    output logic [4:0]                         bi_o,
    output logic [1:0]                         bh_o,
    output logic                               aa_o,
    output logic                               lk_o,
    output logic [addressWidth-1:0]            target_o
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                      state_reg, state_next;
    logic [instMinIdWidth-1:0]   idx_reg, idx_next;
    logic                        invalid_reg, invalid_next;
    logic                        load;

    // Fields of the incoming word (instruction bit 0 is the MSB of the vector)
    logic [5:0]              primary;
    logic [9:0]              xo;
    logic [4:0]              bo_in;
    logic                    lk_in;
    logic                    dec_legal, dec_cond, dec_ctr;
    logic [opcodeSize-1:0]   dec_opc;
    logic [addressWidth-1:0] dec_offset;
    logic [instMinIdWidth-1:0] dec_cnt;

    assign primary = instruction_i[31:26];
    assign xo      = instruction_i[10:1];
    assign bo_in   = instruction_i[25:21];
    assign lk_in   = instruction_i[0];

    // Held instruction
    logic [addressWidth-1:0]            addr_reg, offset_reg;
    logic [instructionCounterWidth-1:0] majid_reg;
    logic [PidSize-1:0]                 pid_reg;
    logic [TidSize-1:0]                 tid_reg;
    logic                               is64_reg, aa_reg, lk_reg, ctr_reg;
    logic [4:0]                         bo_reg, bi_reg;
    logic [1:0]                         bh_reg;
    logic [opcodeSize-1:0]              opc_reg;
    logic [instMinIdWidth-1:0]          cnt_reg;

    logic                      emit, last, accept;
    logic [instMinIdWidth-1:0] slot;   // 0 = CTRDEC, 1 = branch, 2 = LRUPD
    logic [addressWidth-1:0]   tgt_calc;

    // Classify the incoming word and derive its branch offset and uop count
    always_comb begin
        dec_legal  = 1'b0;
        dec_cond   = 1'b0;
        dec_opc    = '0;
        dec_offset = '0;
        case (primary)
            6'd16: begin
                dec_legal  = 1'b1;
                dec_cond   = 1'b1;
                dec_opc    = opcodeSize'(OPC_BC);
                dec_offset = {{(addressWidth-16){instruction_i[15]}}, instruction_i[15:2], 2'b00};
            end
            6'd18: begin
                dec_legal  = 1'b1;
                dec_opc    = opcodeSize'(OPC_B);
                dec_offset = {{(addressWidth-26){instruction_i[25]}}, instruction_i[25:2], 2'b00};
            end
            6'd19: begin
                dec_cond = 1'b1;
                case (xo)
                    10'd16:  begin dec_legal = 1'b1;     dec_opc = opcodeSize'(OPC_BCLR);  end
                    // Decrementing CTR while branching to CTR is undefined
                    10'd528: begin dec_legal = bo_in[2]; dec_opc = opcodeSize'(OPC_BCCTR); end
                    10'd560: begin dec_legal = 1'b1;     dec_opc = opcodeSize'(OPC_BCTAR); end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_ctr = dec_cond && !bo_in[2];
    assign dec_cnt = instMinIdWidth'(1) + instMinIdWidth'(dec_ctr) + instMinIdWidth'(lk_in);

    assign emit    = (state_reg == EMIT);
    assign last    = (idx_reg == cnt_reg - instMinIdWidth'(1));
    assign stall_o = emit && !(last && !stall_i);
    assign accept  = enable_i && !stall_o;
    assign slot    = idx_reg + (ctr_reg ? instMinIdWidth'(0) : instMinIdWidth'(1));

    // Next-state: advance through the crack, reload on a same-edge accept
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        invalid_next = 1'b0;
        load         = 1'b0;
        if (emit && !stall_i) begin
            if (last) state_next = IDLE;
            else      idx_next   = idx_reg + instMinIdWidth'(1);
        end
        if (accept) begin
            if (dec_legal) begin
                state_next = EMIT;
                idx_next   = '0;
                load       = 1'b1;
            end else begin
                state_next   = IDLE;
                invalid_next = 1'b1;
            end
        end
    end

    // Control state register
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            invalid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            invalid_reg <= invalid_next;
        end
    end

    // Capture the accepted instruction for the duration of its crack
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            addr_reg   <= '0;
            offset_reg <= '0;
            majid_reg  <= '0;
            pid_reg    <= '0;
            tid_reg    <= '0;
            is64_reg   <= 1'b0;
            aa_reg     <= 1'b0;
            lk_reg     <= 1'b0;
            ctr_reg    <= 1'b0;
            bo_reg     <= '0;
            bi_reg     <= '0;
            bh_reg     <= '0;
            opc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (load) begin
            addr_reg   <= instructionAddress_i;
            offset_reg <= dec_offset;
            majid_reg  <= instructionMajId_i;
            pid_reg    <= instructionPid_i;
            tid_reg    <= instructionTid_i;
            is64_reg   <= is64Bit_i;
            aa_reg     <= instruction_i[1];
            lk_reg     <= lk_in;
            ctr_reg    <= dec_ctr;
            // Unconditional b has no BO/BI/BH fields
            bo_reg     <= (primary == 6'd18) ? 5'd0 : bo_in;
            bi_reg     <= (primary == 6'd18) ? 5'd0 : instruction_i[20:16];
            bh_reg     <= (primary == 6'd18) ? 2'd0 : instruction_i[12:11];
            opc_reg    <= dec_opc;
            cnt_reg    <= dec_cnt;
        end
    end

`ifdef BRANCH_TARGET_CALC_EN
    // Per-uop target: none for CTRDEC, branch target, or link address
    always_comb begin
        tgt_calc = '0;
        if (slot == instMinIdWidth'(1))
            tgt_calc = aa_reg ? offset_reg : addr_reg + offset_reg;
        else if (slot == instMinIdWidth'(2))
            tgt_calc = addr_reg + addressWidth'(4);
        if (!is64_reg)
            tgt_calc = {{(addressWidth-32){1'b0}}, tgt_calc[31:0]};
    end
`else
    // Without the adders the raw sign-extended offset travels with every uop
    always_comb begin
        tgt_calc = offset_reg;
    end
`endif

    // Drive the current uop; data outputs read zero whenever no uop is valid
    always_comb begin
        enable_o             = emit;
        invalid_o            = invalid_reg;
        opcode_o             = '0;
        functionalUnitType_o = '0;
        instructionAddress_o = '0;
        instMajId_o          = '0;
        instPid_o            = '0;
        instTid_o            = '0;
        is64Bit_o            = 1'b0;
        instMinId_o          = '0;
        numMicroOps_o        = '0;
        bo_o                 = '0;
        bi_o                 = '0;
        bh_o                 = '0;
        aa_o                 = 1'b0;
        lk_o                 = 1'b0;
        target_o             = '0;
        if (emit) begin
            if (slot == instMinIdWidth'(0)) begin
                opcode_o             = opcodeSize'(OPC_CTRDEC);
                functionalUnitType_o = funcUnitCodeSize'(FXUnitId);
            end else if (slot == instMinIdWidth'(1)) begin
                opcode_o             = opc_reg;
                functionalUnitType_o = funcUnitCodeSize'(BranchUnitID);
            end else begin
                opcode_o             = opcodeSize'(OPC_LRUPD);
                functionalUnitType_o = funcUnitCodeSize'(BranchUnitID);
            end
            instructionAddress_o = addr_reg;
            instMajId_o          = majid_reg;
            instPid_o            = pid_reg;
            instTid_o            = tid_reg;
            is64Bit_o            = is64_reg;
            instMinId_o          = idx_reg;
            numMicroOps_o        = cnt_reg;
            bo_o                 = bo_reg;
            bi_o                 = bi_reg;
            bh_o                 = bh_reg;
            aa_o                 = aa_reg;
            lk_o                 = lk_reg;
            target_o             = tgt_calc;
        end
    end

endmodule
